// File: rtl/axis_pkt_dispatcher.sv
// Packet dispatcher: routes whole AXI-Stream packets to an 8-bit pass-through port
// or a 16-bit byte-packing port, configured and monitored over AXI4-Lite.
module axis_pkt_dispatcher #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [7:0]  axis_slv_tdata,
    input  logic        axis_slv_tvalid,
    output logic        axis_slv_tready,
    input  logic        axis_slv_tlast,

    output logic [7:0]  axis_mst0_tdata,
    output logic        axis_mst0_tvalid,
    input  logic        axis_mst0_tready,
    output logic        axis_mst0_tlast,

    output logic [15:0] axis_mst1_tdata,
    output logic        axis_mst1_tvalid,
    input  logic        axis_mst1_tready,
    output logic        axis_mst1_tlast,

    input  logic [31:0] aximm_slv_awaddr,
    input  logic        aximm_slv_awvalid,
    output logic        aximm_slv_awready,
    input  logic [31:0] aximm_slv_wdata,
    input  logic        aximm_slv_wvalid,
    output logic        aximm_slv_wready,
    output logic [1:0]  aximm_slv_bresp,
    output logic        aximm_slv_bvalid,
    input  logic        aximm_slv_bready,
    input  logic [31:0] aximm_slv_araddr,
    input  logic        aximm_slv_arvalid,
    output logic        aximm_slv_arready,
    output logic [31:0] aximm_slv_rdata,
    output logic        aximm_slv_rvalid,
    input  logic        aximm_slv_rready
);

    typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_t;

    state_t           state, state_nxt;
    logic             en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             rr_ptr, dest, dest_nxt;
    logic [7:0]       lo_byte;
    logic             lo_held;
    logic [15:0]      w_data;
    logic             w_valid, w_last;
    logic             aw_held;
    logic [1:0]       aw_word;
    logic             bvalid_q, rvalid_q;
    logic [31:0]      rdata_q, rd_mux;

    logic start, slv_hs, mst0_done, mst1_done, wr_fire, ar_fire, pack_load;
    logic unused_bits;

    assign unused_bits = ^{aximm_slv_awaddr[31:4], aximm_slv_awaddr[1:0],
                           aximm_slv_araddr[31:4], aximm_slv_araddr[1:0],
                           aximm_slv_wdata[31:3]};

    assign start     = en && axis_slv_tvalid;
    assign slv_hs    = axis_slv_tvalid && axis_slv_tready;
    assign mst0_done = (state == ROUTE0) && slv_hs && axis_slv_tlast;
    assign mst1_done = w_valid && axis_mst1_tready && w_last;
    assign pack_load = (state == ROUTE1) && slv_hs && (lo_held || axis_slv_tlast);

    always_comb begin
        case (mode)
            2'd0:    dest_nxt = 1'b0;
            2'd1:    dest_nxt = 1'b1;
            2'd2:    dest_nxt = rr_ptr;
            default: dest_nxt = axis_slv_tdata[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = dest_nxt ? ROUTE1 : ROUTE0;
            ROUTE0:  if (mst0_done) state_nxt = IDLE;
            ROUTE1:  if (mst1_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port 1 stops taking bytes once the closing word is formed, so no beat of the
    // next packet slips in before the FSM returns to IDLE.
    always_comb begin
        axis_slv_tready  = 1'b0;
        axis_mst0_tvalid = 1'b0;
        axis_mst0_tdata  = 8'h00;
        axis_mst0_tlast  = 1'b0;
        case (state)
            ROUTE0: begin
                axis_slv_tready  = axis_mst0_tready;
                axis_mst0_tvalid = axis_slv_tvalid;
                axis_mst0_tdata  = axis_slv_tdata;
                axis_mst0_tlast  = axis_slv_tlast;
            end
            ROUTE1:  axis_slv_tready = !w_valid || (axis_mst1_tready && !w_last);
            default: ;
        endcase
    end

    assign axis_mst1_tdata  = w_data;
    assign axis_mst1_tvalid = w_valid;
    assign axis_mst1_tlast  = w_valid && w_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            dest    <= 1'b0;
            rr_ptr  <= 1'b0;
            lo_byte <= 8'h00;
            lo_held <= 1'b0;
            w_data  <= 16'h0000;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                dest <= dest_nxt;
                if (mode == 2'd2) rr_ptr <= ~rr_ptr;
            end
            if (state == ROUTE1 && slv_hs) begin
                if (lo_held) begin
                    w_data  <= {axis_slv_tdata, lo_byte};
                    w_last  <= axis_slv_tlast;
                    lo_held <= 1'b0;
                end else if (axis_slv_tlast) begin
                    w_data  <= {8'h00, axis_slv_tdata};
                    w_last  <= 1'b1;
                end else begin
                    lo_byte <= axis_slv_tdata;
                    lo_held <= 1'b1;
                end
            end
            if (pack_load)             w_valid <= 1'b1;
            else if (axis_mst1_tready) w_valid <= 1'b0;
        end
    end

    assign wr_fire = aw_held && aximm_slv_wvalid;
    assign ar_fire = aximm_slv_arvalid && !rvalid_q;

    always_comb begin
        case (aximm_slv_araddr[3:2])
            2'd0:    rd_mux = {29'd0, mode, en};
            2'd1:    rd_mux = 32'(cnt0);
            2'd2:    rd_mux = 32'(cnt1);
            default: rd_mux = {28'd0, lo_held, rr_ptr, dest, state != IDLE};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            mode     <= 2'd0;
            cnt0     <= '0;
            cnt1     <= '0;
            aw_held  <= 1'b0;
            aw_word  <= 2'd0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            if (aximm_slv_awvalid && aximm_slv_awready) begin
                aw_held <= 1'b1;
                aw_word <= aximm_slv_awaddr[3:2];
            end
            if (wr_fire) begin
                aw_held  <= 1'b0;
                bvalid_q <= 1'b1;
                if (aw_word == 2'd0) {mode, en} <= aximm_slv_wdata[2:0];
            end else if (bvalid_q && aximm_slv_bready) begin
                bvalid_q <= 1'b0;
            end
            // A clearing write wins over a same-cycle packet completion.
            if (wr_fire && aw_word == 2'd1)  cnt0 <= '0;
            else if (mst0_done && cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
            if (wr_fire && aw_word == 2'd2)  cnt1 <= '0;
            else if (mst1_done && cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && aximm_slv_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign aximm_slv_awready = !aw_held && !bvalid_q;
    assign aximm_slv_wready  = aw_held;
    assign aximm_slv_bresp   = 2'b00;
    assign aximm_slv_bvalid  = bvalid_q;
    assign aximm_slv_arready = !rvalid_q;
    assign aximm_slv_rvalid  = rvalid_q;
    assign aximm_slv_rdata   = rdata_q;

endmodule

// File: tb/tb_axis_pkt_dispatcher.sv
// Directed bench for axis_pkt_dispatcher; a scoreboard predicts each output beat as
// bytes are driven, and a narrow-counter twin instance checks saturation.
module tb_axis_pkt_dispatcher;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [7:0]  m0_tdata;
    logic        m0_tvalid, m0_tlast, m0_tready = 1'b1;
    logic [15:0] m1_tdata;
    logic        m1_tvalid, m1_tlast, m1_tready = 1'b1;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp;

    logic        b_s_tready, b_m0_tvalid, b_m0_tlast, b_m1_tvalid, b_m1_tlast;
    logic [7:0]  b_m0_tdata;
    logic [15:0] b_m1_tdata;
    logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
    logic [1:0]  b_bresp;
    logic [31:0] b_rdata;

    int tests = 0, fails = 0;
    logic [8:0]  q0[$];
    logic [16:0] q1[$];
    bit   bp = 0;
    logic rdy0_def = 1'b1, rdy1_def = 1'b1;
    int   vld1_cnt = 0;
    logic [31:0] rd, rd2;

    axis_pkt_dispatcher dut (
        .clk(clk), .reset(reset),
        .axis_slv_tdata(s_tdata), .axis_slv_tvalid(s_tvalid), .axis_slv_tready(s_tready), .axis_slv_tlast(s_tlast),
        .axis_mst0_tdata(m0_tdata), .axis_mst0_tvalid(m0_tvalid), .axis_mst0_tready(m0_tready), .axis_mst0_tlast(m0_tlast),
        .axis_mst1_tdata(m1_tdata), .axis_mst1_tvalid(m1_tvalid), .axis_mst1_tready(m1_tready), .axis_mst1_tlast(m1_tlast),
        .aximm_slv_awaddr(awaddr), .aximm_slv_awvalid(awvalid), .aximm_slv_awready(awready),
        .aximm_slv_wdata(wdata), .aximm_slv_wvalid(wvalid), .aximm_slv_wready(wready),
        .aximm_slv_bresp(bresp), .aximm_slv_bvalid(bvalid), .aximm_slv_bready(bready),
        .aximm_slv_araddr(araddr), .aximm_slv_arvalid(arvalid), .aximm_slv_arready(arready),
        .aximm_slv_rdata(rdata), .aximm_slv_rvalid(rvalid), .aximm_slv_rready(rready)
    );

    axis_pkt_dispatcher #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .axis_slv_tdata(s_tdata), .axis_slv_tvalid(s_tvalid), .axis_slv_tready(b_s_tready), .axis_slv_tlast(s_tlast),
        .axis_mst0_tdata(b_m0_tdata), .axis_mst0_tvalid(b_m0_tvalid), .axis_mst0_tready(m0_tready), .axis_mst0_tlast(b_m0_tlast),
        .axis_mst1_tdata(b_m1_tdata), .axis_mst1_tvalid(b_m1_tvalid), .axis_mst1_tready(m1_tready), .axis_mst1_tlast(b_m1_tlast),
        .aximm_slv_awaddr(awaddr), .aximm_slv_awvalid(awvalid), .aximm_slv_awready(b_awready),
        .aximm_slv_wdata(wdata), .aximm_slv_wvalid(wvalid), .aximm_slv_wready(b_wready),
        .aximm_slv_bresp(b_bresp), .aximm_slv_bvalid(b_bvalid), .aximm_slv_bready(bready),
        .aximm_slv_araddr(araddr), .aximm_slv_arvalid(arvalid), .aximm_slv_arready(b_arready),
        .aximm_slv_rdata(b_rdata), .aximm_slv_rvalid(b_rvalid), .aximm_slv_rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream readiness: random under backpressure, otherwise per-port default.
    initial forever begin
        @(posedge clk); #1;
        if (bp) begin
            m0_tready = 1'($urandom_range(0, 1));
            m1_tready = 1'($urandom_range(0, 1));
        end else begin
            m0_tready = rdy0_def;
            m1_tready = rdy1_def;
        end
    end

    logic [15:0] p_d;
    logic        p_v = 0, p_r = 0, p_l = 0, p_rst = 1;
    logic [8:0]  e0;
    logic [16:0] e1;
    always @(negedge clk) begin
        if (m1_tvalid) vld1_cnt++;
        if (!reset && m0_tvalid && m0_tready) begin
            tests++;
            e0 = (q0.size() != 0) ? q0.pop_front() : 9'h1xx;
            assert ({m0_tlast, m0_tdata} === e0) else begin
                fails++;
                $error("FAIL mst0_beat: observed %0h expected %0h", {m0_tlast, m0_tdata}, e0);
            end
        end
        if (!reset && m1_tvalid && m1_tready) begin
            tests++;
            e1 = (q1.size() != 0) ? q1.pop_front() : 17'h1xxxx;
            assert ({m1_tlast, m1_tdata} === e1) else begin
                fails++;
                $error("FAIL mst1_word: observed %0h expected %0h", {m1_tlast, m1_tdata}, e1);
            end
        end
        if (p_v && !p_r && !p_rst) begin
            tests++;
            assert ({m1_tvalid, m1_tlast, m1_tdata} === {1'b1, p_l, p_d}) else begin
                fails++;
                $error("FAIL mst1_stable: observed %0h expected %0h", {m1_tvalid, m1_tlast, m1_tdata}, {1'b1, p_l, p_d});
            end
        end
        p_v = m1_tvalid; p_r = m1_tready; p_l = m1_tlast; p_d = m1_tdata; p_rst = reset;
    end

    function automatic bq_t mk(input logic [7:0] base, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
        return q;
    endfunction

    task automatic send_pkt(input bq_t b, input bit d);
        int t;
        logic [7:0] lo;
        bit have = 0;
        for (int i = 0; i < b.size(); i++) begin
            bit last = (i == b.size() - 1);
            if (!d) q0.push_back({last, b[i]});
            else if (have) begin q1.push_back({last, b[i], lo}); have = 0; end
            else if (last) q1.push_back({1'b1, 8'h00, b[i]});
            else begin lo = b[i]; have = 1; end
        end
        for (int i = 0; i < b.size(); i++) begin
            s_tdata = b[i]; s_tlast = (i == b.size() - 1); s_tvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!s_tready && t < 500);
            if (!s_tready) chk("slv_accept_tmo", {31'd0, s_tready}, 1);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 2000) begin @(negedge clk); t++; end
        chk("drain", q0.size() + q1.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
        int t;
        awaddr = a; awvalid = 1'b1; t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 100);
        @(posedge clk); #1;
        awvalid = 1'b0; wdata = d; wvalid = 1'b1; t = 0;
        do begin @(negedge clk); t++; end while (!wready && t < 100);
        @(posedge clk); #1;
        wvalid = 1'b0; t = 0;
        do begin @(negedge clk); t++; end while (!bvalid && t < 100);
        chk("wr_bresp", {29'd0, bvalid, bresp}, 32'h4);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d2);
        int t;
        araddr = a; arvalid = 1'b1; t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 100);
        @(posedge clk); #1;
        arvalid = 1'b0; t = 0;
        do begin @(negedge clk); t++; end while (!rvalid && t < 100);
        if (!rvalid) chk("rd_tmo", {31'd0, rvalid}, 1);
        d = rdata; d2 = b_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rcnt, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 1);
        chk("rst_arready", {31'd0, arready}, 1);
        chk("rst_bvalid_rvalid", {30'd0, bvalid, rvalid}, 0);
        chk("rst_tvalids", {30'd0, m0_tvalid, m1_tvalid}, 0);
        chk("rst_slv_tready", {31'd0, s_tready}, 0);
        @(posedge clk); #1; reset = 1'b0;
        axi_read(32'h6000_0000, rd, rd2); chk("rst_ctrl", rd, 0);

        // mode 0
        axi_write(32'h6000_0000, 1);
        base = vld1_cnt;
        send_pkt(mk(8'h01, 11), 0);
        drain();
        chk("m0_no_mst1", vld1_cnt - base, 0);
        axi_read(32'h6000_0004, rd, rd2); chk("m0_cnt0", rd, 1);

        // mode 1
        axi_write(32'h6000_0000, 3);
        send_pkt(mk(8'h01, 11), 1);
        drain();
        axi_read(32'h6000_0008, rd, rd2); chk("m1_cnt1", rd, 1);

        // mode 2 with random backpressure
        axi_write(32'h6000_0004, 0);
        axi_write(32'h6000_0008, 0);
        axi_write(32'h6000_0000, 5);
        bp = 1;
        send_pkt(mk(8'h10, 3), 0);
        send_pkt(mk(8'h20, 3), 1);
        send_pkt(mk(8'h30, 3), 0);
        send_pkt(mk(8'h40, 3), 1);
        drain();
        bp = 0;
        axi_read(32'h6000_0004, rd, rd2); chk("rr_cnt0", rd, 2);
        axi_read(32'h6000_0008, rd, rd2); chk("rr_cnt1", rd, 2);
        axi_read(32'h6000_000C, rd, rd2); chk("rr_ptr", {31'd0, rd[2]}, 0);

        // mode 3 content routing
        axi_write(32'h6000_0000, 7);
        send_pkt(mk(8'h81, 2), 1);
        send_pkt(mk(8'h80, 3), 0);
        drain();

        // CTRL changes mid-packet
        axi_write(32'h6000_0000, 1);
        fork
            send_pkt(mk(8'h50, 16), 0);
            begin repeat (3) @(posedge clk); #1; axi_write(32'h6000_0000, 3); end
        join
        send_pkt(mk(8'h60, 4), 1);
        fork
            send_pkt(mk(8'h70, 16), 1);
            begin repeat (3) @(posedge clk); #1; axi_write(32'h6000_0000, 0); end
        join
        drain();
        s_tdata = 8'h55; s_tlast = 1'b1; s_tvalid = 1'b1; rcnt = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (s_tready) rcnt++; end
        chk("dis_tready", rcnt, 0);
        axi_read(32'h6000_000C, rd, rd2); chk("dis_status", rd & 32'h3, 32'h2);
        @(posedge clk); #1; s_tvalid = 1'b0; s_tlast = 1'b0;

        // counter clear and saturation
        axi_write(32'h6000_0004, 0);
        axi_read(32'h6000_0004, rd, rd2); chk("clr_cnt0", rd, 0); chk("clr_cnt0_w2", rd2, 0);
        axi_write(32'h6000_0000, 1);
        for (int i = 0; i < 5; i++) send_pkt(mk(8'(8'h90 + 8'(2 * i)), 2), 0);
        drain();
        axi_read(32'h6000_0004, rd, rd2); chk("cnt0_five", rd, 5); chk("cnt0_sat_w2", rd2, 3);

        // reset mid port-1 packet, word stalled downstream
        axi_write(32'h6000_0000, 3);
        rdy1_def = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            s_tdata = 8'hA1 + 8'(i); s_tlast = 1'b0; s_tvalid = 1'b1; t = 0;
            do begin @(negedge clk); t++; end while (!s_tready && t < 100);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_word", {15'd0, m1_tvalid, m1_tdata}, 32'h1A2A1);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_tvalids", {30'd0, m0_tvalid, m1_tvalid}, 0);
        @(posedge clk); #1; reset = 1'b0; rdy1_def = 1'b1;
        axi_read(32'h6000_0000, rd, rd2); chk("post_rst_ctrl", rd, 0);
        axi_read(32'h6000_000C, rd, rd2); chk("post_rst_status", rd, 0);

        chk("queues_empty", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_pkt_dispatcher.md
# axis_pkt_dispatcher

Packet-level scheduler for the example design's datapath. It takes the 8-bit AXI-Stream input and routes each whole packet to one of two AXI-Stream outputs: an 8-bit pass-through on port 0, or a 16-bit byte-packed stream on port 1. The routing policy is set through a four-register AXI4-Lite slave, which also exposes per-port packet counters and status. It sits between the stream source and the two downstream consumers, in place of a fixed fan-out.

## Interface
- CNT_W, 16, packet counter width (1..32); counters are zero-extended to 32 bits on read
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- axis_slv_tdata / tvalid / tready / tlast  in/in/out/in  8/1/1/1  input stream
- axis_mst0_tdata / tvalid / tready / tlast  out/out/in/out  8/1/1/1  byte output
- axis_mst1_tdata / tvalid / tready / tlast  out/out/in/out  16/1/1/1  packed output
- aximm_slv_awaddr / awvalid / awready  in/in/out  32/1/1  write address
- aximm_slv_wdata / wvalid / wready  in/in/out  32/1/1  write data (no strobes; full-word writes)
- aximm_slv_bresp / bvalid / bready  out/out/in  2/1/1  write response; bresp is always 2'b00
- aximm_slv_araddr / arvalid / arready  in/in/out  32/1/1  read address
- aximm_slv_rdata / rvalid / rready  out/out/in  32/1/1  read data

## Operation
- **Register decode:** offset = addr[3:0]; upper address bits are ignored (base 0x6000_0000 is decoded upstream).
- **0x0 CTRL** (R/W, reset 0)
  - [0] enable
  - [2:1] mode: 0 = always port 0; 1 = always port 1; 2 = round-robin per packet, starting at port 0 after reset; 3 = content-routed, where port = bit 0 of the packet's first byte.
- **0x4 CNT0 / 0x8 CNT1**
  - Packets completed on port 0 / port 1; a packet counts on the output tlast handshake.
  - Counters saturate at all-ones.
  - Any write clears the counter. Clear wins over a simultaneous increment.
- **0xC STATUS** (RO)
  - [0] busy (FSM not IDLE)
  - [1] current/last destination
  - [2] round-robin pointer
  - [3] pack register holds a low byte
- Writes to STATUS are ignored. Reads of unmapped offsets cannot occur; all 16 offsets alias onto the 4 words by addr[3:2].
- **Dispatch FSM:** IDLE, ROUTE0, ROUTE1.
  - IDLE: axis_slv_tready=0. If enable and axis_slv_tvalid, latch the destination from the mode (peeking tdata for mode 3, without consuming the beat) and go to ROUTEx. The round-robin pointer toggles on every mode-2 decision.
  - CTRL changes take effect only at the IDLE decision. Changing mode or clearing enable mid-packet never truncates or reroutes the current packet.
- **ROUTE0:** combinational pass-through.
  - mst0_tvalid = slv_tvalid, slv_tready = mst0_tready; tdata and tlast are passed through.
  - On the tlast handshake, go to IDLE.
- **ROUTE1:** byte packing.
  - The first byte goes to the low byte [7:0], the second to [15:8]. The word is presented with tvalid when both bytes are held.
  - If tlast arrives on a low byte, the word is presented immediately with [15:8]=0 and tlast=1.
  - slv_tready=0 while a word is pending (mst1_tvalid && !mst1_tready).
  - After the mst1 tlast handshake, go to IDLE.
- **AXI-Lite write channel**
  - awready=1 while no address is held and bvalid=0.
  - After the aw handshake, wready=1. After the w handshake, the register is updated and bvalid=1 until bready.
  - AW and W are never accepted in the same cycle.
- **AXI-Lite read channel**
  - arready = !rvalid. rdata is registered and rvalid is asserted the cycle after the ar handshake.
  - rdata is held stable until rready.
- **Reset values:** every output 0, except awready=1 and arready=1. CTRL, counters, round-robin pointer and pack register are all 0; FSM is IDLE.
- **Reset mid-packet:** the partial packet and any half-packed word are discarded. No output tvalid is asserted in the cycle after reset is sampled.

## Timing
- Packet start: slv_tvalid in IDLE at cycle N → ROUTEx at N+1. The first beat can be accepted at N+1.
- Port 0 latency: 0 cycles (combinational).
- Port 1 latency:
  - mst1_tvalid rises 1 cycle after the second byte's handshake, or 1 cycle after a lone tlast byte.
  - Peak throughput is 1 word per 2 input beats.
- Packet gap: output tlast handshake at cycle M → IDLE at M+1 → next ROUTE at M+2 at the earliest.
- Output stability: tdata, tlast and tvalid are held stable while tvalid && !tready on all outputs.
- Register write latency: CTRL is visible to the FSM the cycle after the w handshake; bvalid is asserted in the same cycle.
- Read latency: 1 cycle from ar handshake to rvalid.

## Test plan
- **Mode 0:** write CTRL=0x1, send 11-byte packet 0x01..0x0B → 11 beats on mst0, tlast on 0x0B; mst1_tvalid never rises; CNT0 reads 1.
- **Mode 1:** write CTRL=0x3, send the same 11 bytes → mst1 words 0x0201, 0x0403, 0x0605, 0x0807, 0x0A09, 0x000B; tlast only on 0x000B; CNT1 reads 1.
- **Mode 2 under backpressure:** write CTRL=0x5, send four 3-byte packets with random tready on both outputs → destinations 0,1,0,1; no data lost; CNT0=2, CNT1=2; STATUS[2]=0.
- **Mode 3:** write CTRL=0x7; packet starting 0x81 → mst1; packet starting 0x80 → mst0.
- **Mid-packet config change:** during a mode-0 packet, write CTRL=0x3 → the packet completes on mst0 and the next packet goes to mst1. Write CTRL=0x0 mid-packet → the packet completes, then slv_tready stays 0 and STATUS[0]=0.
- **Counters and reset:**
  - Write 0x4 → CNT0 reads 0.
  - Force CNT_W=2, send 5 packets → counter reads 3 (saturated).
  - Assert reset mid mst1 packet → next cycle all tvalid=0, CTRL and STATUS read 0.
